// File: rtl/an13_pkg.sv
// an13_pkg: shared constants and result type for the AN-code (A = 13)
// Barrett-reduction decoder and its arbitrated front end.
package an13_pkg;

  localparam int A      = 13;  // AN-code multiplier
  localparam int CW_W   = 6;   // codeword width
  localparam int Q_W    = 3;   // decoded data (quotient) width
  localparam int R_W    = 4;   // remainder width, holds 0..12
  localparam int NREQ   = 2;   // requesters sharing the decoder
  localparam int M      = 19;  // Barrett multiplier, floor(256/13)
  localparam int SHIFT  = 8;   // Barrett shift, log2(256)
  localparam int PROD_W = 11;  // width of x*M for a 6-bit x

  typedef struct packed {
    logic [Q_W-1:0] q;
    logic [R_W-1:0] r;
    logic           error;
  } dec_result_t;

endpackage

// File: rtl/an13_dec_arbiter_if.sv
// an13_dec_arbiter_if: requester-side and consumer-side handshake bundle of
// the shared AN-13 decoder. The master modport is the environment (producers
// and consumer), the slave modport is the arbiter itself.
interface an13_dec_arbiter_if;
  import an13_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*CW_W-1:0] req_word;
  logic [NREQ-1:0]      req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [Q_W-1:0]       out_q;
  logic [R_W-1:0]       out_r;
  logic                 out_error;
  logic                 out_id;

  modport master (
    output req_valid, req_word, out_ready,
    input  req_ready, out_valid, out_q, out_r, out_error, out_id
  );

  modport slave (
    input  req_valid, req_word, out_ready,
    output req_ready, out_valid, out_q, out_r, out_error, out_id
  );

endinterface

// File: rtl/an13_barrett_dec.sv
// an13_barrett_dec: purely combinational AN-13 decode of one codeword using
// Barrett reduction (m = 19, shift 8) with a single correction step.
// Usable standalone or inside the arbitrated pipeline.
module an13_barrett_dec
  import an13_pkg::*;
(
  input  logic [CW_W-1:0] x,
  output dec_result_t     res
);

  localparam logic [CW_W-1:0] A_CW = CW_W'(A);

  logic [PROD_W-1:0] prod;
  logic [Q_W-1:0]    q_est;
  logic [CW_W-1:0]   r_est;

  // Estimate the quotient, then fix the one-off underestimate Barrett allows.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    res   = '0;
    prod  = PROD_W'(x) * PROD_W'(M);
    q_est = Q_W'(prod >> SHIFT);
    r_est = x - CW_W'(A * int'(q_est));
    if (r_est >= A_CW) begin
      res.q = q_est + Q_W'(1);
      res.r = R_W'(r_est - A_CW);
    end else begin
      res.q = q_est;
      res.r = R_W'(r_est);
    end
    res.error = (res.r != '0);
  end

endmodule

// File: rtl/an13_dec_arbiter.sv
// an13_dec_arbiter: round-robin front end sharing one AN-13 Barrett decoder
// between two codeword sources, followed by a two-stage stallable pipeline.
// Optional macro AN13_DEC_ERRCNT_EN enables the saturating errored-result
// counter; without it err_count is tied to zero.
module an13_dec_arbiter
  import an13_pkg::*;
#(
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  an13_dec_arbiter_if.slave   bus,
  output logic [ERRCNT_W-1:0] err_count
);

  logic            last;        // requester that won the latest accepted transfer
  logic            s1_valid;
  logic [CW_W-1:0] s1_word;
  logic            s1_id;
  logic            out_valid_q;
  logic [Q_W-1:0]  out_q_q;
  logic [R_W-1:0]  out_r_q;
  logic            out_error_q;
  logic            out_id_q;

  logic            s1_en;
  logic            s2_en;
  logic            gnt_id;
  logic [NREQ-1:0] grant;
  logic            accept;
  logic [CW_W-1:0] gnt_word;
  dec_result_t     s1_dec;

  // Pick the winner, derive stage enables and the per-requester accept.
  always_comb begin
    s2_en    = !out_valid_q || bus.out_ready;
    s1_en    = !s1_valid || s2_en;
    gnt_id   = (&bus.req_valid) ? !last : bus.req_valid[1];
    grant    = (|bus.req_valid) ? (NREQ'(1) << gnt_id) : '0;
    // No transfer is offered while reset is held, so nothing is lost to it.
    bus.req_ready = grant & {NREQ{s1_en && !rst}};
    accept   = |(bus.req_valid & bus.req_ready);
    gnt_word = bus.req_word[int'(gnt_id) * CW_W +: CW_W];
  end

  // Stage 1: capture the granted word and its source; advance the pointer.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    if (rst) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_id    <= 1'b0;
      last     <= 1'b1;
    end else begin
      if (s1_en) begin
        s1_valid <= accept;
        if (accept) begin
          s1_word <= gnt_word;
          s1_id   <= gnt_id;
        end
      end
      if (accept) last <= gnt_id;
    end
  end

  an13_barrett_dec u_dec (
    .x   (s1_word),
    .res (s1_dec)
  );

  // Stage 2: register the decode; hold everything while the consumer stalls.
  always_ff @(posedge clk) begin
    // NOTE: the result registers are cleared as well as the valid bit, so a
    // consumer never sees stale data after reset even if it ignores out_valid.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      out_r_q     <= '0;
      out_error_q <= 1'b0;
      out_id_q    <= 1'b0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_q_q     <= s1_dec.q;
        out_r_q     <= s1_dec.r;
        out_error_q <= s1_dec.error;
        out_id_q    <= s1_id;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_q     = out_q_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_error = out_error_q;
  assign bus.out_id    = out_id_q;

`ifdef AN13_DEC_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt;

  // Count errored results as they are handed over; stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (out_valid_q && bus.out_ready && out_error_q && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

  assign err_count = err_cnt;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_an13_dec_arbiter.sv
// tb_an13_dec_arbiter: directed vectors with hand-computed decodes, a driver
// that records accepted words into a scoreboard, and an independent monitor
// that compares every presented result against the scoreboard head.
module tb_an13_dec_arbiter;
  import an13_pkg::*;

  localparam int ERRCNT_W = 2;
  localparam int CNT_MAX  = (1 << ERRCNT_W) - 1;
  localparam int IDLE_MAX = 200;

  typedef struct {
    logic [CW_W-1:0] w;
    logic [Q_W-1:0]  q;
    logic [R_W-1:0]  r;
    logic            e;
  } vec_t;

  typedef struct {
    logic [Q_W-1:0] q;
    logic [R_W-1:0] r;
    logic           e;
    logic           id;
    int             acc;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [ERRCNT_W-1:0] err_count;

  an13_dec_arbiter_if bus ();

  an13_dec_arbiter #(.ERRCNT_W(ERRCNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  vec_t src0[$];
  vec_t src1[$];
  exp_t exp_q[$];
  int   acc_log[$];
  int   cyc       = 0;
  int   n_vec     = 0;
  int   n_err     = 0;
  int   err_model = 0;
  bit   chk_lat   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input int w, input int q, input int r, input int e);
    vec_t v;
    v.w = CW_W'(w);
    v.q = Q_W'(q);
    v.r = R_W'(r);
    v.e = 1'(e);
    return v;
  endfunction

  // Expected counter reading after n errored deliveries since reset.
  function automatic int sat(input int n);
`ifdef AN13_DEC_ERRCNT_EN
    return (n > CNT_MAX) ? CNT_MAX : n;
`else
    return 0 * n;
`endif
  endfunction

  // Driver: record accepts at mid-cycle, present queue heads after each edge.
  initial begin : driver
    bus.req_valid = '0;
    bus.req_word  = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.req_valid != '0)
        check("ready_legal",
              {30'b0, |(bus.req_ready & ~bus.req_valid), &bus.req_ready}, 32'd0);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          vec_t v;
          exp_t x;
          if (i == 0) v = src0.pop_front();
          else        v = src1.pop_front();
          x.q   = v.q;
          x.r   = v.r;
          x.e   = v.e;
          x.id  = 1'(i);
          x.acc = cyc;
          exp_q.push_back(x);
          acc_log.push_back(i);
        end
      end
      @(posedge clk);
      #2;
      bus.req_valid[0] = (src0.size() > 0);
      if (src0.size() > 0) bus.req_word[0 +: CW_W] = src0[0].w;
      bus.req_valid[1] = (src1.size() > 0);
      if (src1.size() > 0) bus.req_word[CW_W +: CW_W] = src1[0].w;
    end
  end

  // Monitor: compare whatever the DUT presents against the scoreboard head.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got q=%0d r=%0d id=%0d, expected no output",
                   bus.out_q, bus.out_r, bus.out_id);
        end else begin
          exp_t x;
          x = exp_q[0];
          check("out_q", 32'(bus.out_q), 32'(x.q));
          check("out_r", 32'(bus.out_r), 32'(x.r));
          check("out_error", 32'(bus.out_error), 32'(x.e));
          check("out_id", 32'(bus.out_id), 32'(x.id));
          if (bus.out_ready) begin
            check("err_count_live", 32'(err_count), 32'(err_model));
            if (chk_lat) check("latency", 32'(cyc - x.acc), 32'd2);
            void'(exp_q.pop_front());
`ifdef AN13_DEC_ERRCNT_EN
            if (x.e && err_model < CNT_MAX) err_model++;
`endif
          end
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < IDLE_MAX; k++) begin
      @(posedge clk);
      #3;
      if (exp_q.size() == 0 && src0.size() == 0 && src1.size() == 0 && !bus.out_valid) break;
    end
    if (k == IDLE_MAX) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d pending results, expected 0", name, exp_q.size());
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    src0.delete();
    src1.delete();
    exp_q.delete();
    acc_log.delete();
    err_model = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : main
    int ec_exp[5];
    int k;
`ifdef AN13_DEC_ERRCNT_EN
    ec_exp = '{1, 2, 3, 3, 3};
`else
    ec_exp = '{0, 0, 0, 0, 0};
`endif
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_q", 32'(bus.out_q), 32'd0);
    check("rst_out_r", 32'(bus.out_r), 32'd0);
    check("rst_out_error", 32'(bus.out_error), 32'd0);
    check("rst_out_id", 32'(bus.out_id), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);

    // Requester 0, exact multiples; 13, 26, 39, 52 all take the correction path.
    bus.out_ready = 1'b1;
    chk_lat = 1'b1;
    src0.push_back(mk(13, 1, 0, 0));
    src0.push_back(mk(26, 2, 0, 0));
    src0.push_back(mk(39, 3, 0, 0));
    src0.push_back(mk(52, 4, 0, 0));
    wait_idle("t1");
    check("t1_err_count", 32'(err_count), 32'(sat(0)));

    // Requester 1, corrupted words.
    src1.push_back(mk(1, 0, 1, 1));
    src1.push_back(mk(12, 0, 12, 1));
    src1.push_back(mk(27, 2, 1, 1));
    src1.push_back(mk(60, 4, 8, 1));
    wait_idle("t2");
    check("t2_err_count", 32'(err_count), 32'(sat(4)));

    // Both requesters valid together: grants must alternate starting with 0.
    acc_log.delete();
    src0.push_back(mk(39, 3, 0, 0));
    src0.push_back(mk(39, 3, 0, 0));
    src1.push_back(mk(53, 4, 1, 1));
    src1.push_back(mk(53, 4, 1, 1));
    wait_idle("t3");
    check("t3_grants", 32'(acc_log.size()), 32'd4);
    if (acc_log.size() == 4) begin
      check("t3_grant0", 32'(acc_log[0]), 32'd0);
      check("t3_grant1", 32'(acc_log[1]), 32'd1);
      check("t3_grant2", 32'(acc_log[2]), 32'd0);
      check("t3_grant3", 32'(acc_log[3]), 32'd1);
    end
    check("t3_err_count", 32'(err_count), 32'(sat(6)));

    // Backpressure: consumer stalled for five cycles.
    chk_lat = 1'b0;
    bus.out_ready = 1'b0;
    acc_log.delete();
    src0.push_back(mk(0, 0, 0, 0));
    src0.push_back(mk(63, 4, 11, 1));
    src0.push_back(mk(26, 2, 0, 0));
    src0.push_back(mk(40, 3, 1, 1));
    repeat (5) @(posedge clk);
    #3;
    check("t4_accepts_stalled", 32'(acc_log.size()), 32'd2);
    check("t4_req_ready_low", 32'(bus.req_ready), 32'd0);
    check("t4_out_valid_held", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    wait_idle("t4");
    check("t4_accepts_total", 32'(acc_log.size()), 32'd4);
    check("t4_err_count", 32'(err_count), 32'(sat(8)));

    // Reset with two words in flight; requester 0 won last, reset restores priority.
    bus.out_ready = 1'b0;
    acc_log.delete();
    src0.push_back(mk(13, 1, 0, 0));
    src0.push_back(mk(26, 2, 0, 0));
    for (k = 0; k < IDLE_MAX; k++) begin
      @(posedge clk);
      #1;
      if (acc_log.size() == 2) break;
    end
    if (k == IDLE_MAX) begin
      n_vec++;
      n_err++;
      $display("FAIL t5_fill_timeout: got %0d accepts, expected 2", acc_log.size());
    end
    rst = 1'b1;
    src0.delete();
    src1.delete();
    exp_q.delete();
    err_model = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("t5_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_err_count", 32'(err_count), 32'd0);
    acc_log.delete();
    bus.out_ready = 1'b1;
    chk_lat = 1'b1;
    src0.push_back(mk(39, 3, 0, 0));
    src1.push_back(mk(53, 4, 1, 1));
    wait_idle("t5");
    check("t5_grants", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() > 0) check("t5_first_grant", 32'(acc_log[0]), 32'd0);

    // Error counter saturation, one errored word at a time.
    pulse_reset();
    src0.push_back(mk(1, 0, 1, 1));
    wait_idle("t6a");
    check("t6_err_count_1", 32'(err_count), 32'(ec_exp[0]));
    src0.push_back(mk(2, 0, 2, 1));
    wait_idle("t6b");
    check("t6_err_count_2", 32'(err_count), 32'(ec_exp[1]));
    src0.push_back(mk(4, 0, 4, 1));
    wait_idle("t6c");
    check("t6_err_count_3", 32'(err_count), 32'(ec_exp[2]));
    src0.push_back(mk(8, 0, 8, 1));
    wait_idle("t6d");
    check("t6_err_count_4", 32'(err_count), 32'(ec_exp[3]));
    src0.push_back(mk(5, 0, 5, 1));
    wait_idle("t6e");
    check("t6_err_count_5", 32'(err_count), 32'(ec_exp[4]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within 200000 time units");
    $fatal(1, "simulation time limit");
  end

endmodule
